fc_result_collector: RTL
========================

Name: fc_result_collector

Overview:
Output-side reader for the fully_connected layer's result stream. It captures the OUTPUT_SIZE addressed score words into a local buffer and, on fc_done, runs a sequential argmax to produce the classification index and winning score. It also provides a registered random-access readback port for the host or testbench. It sits directly after fully_connected and closes the conv2d -> max_pool -> fully_connected chain.

Parameters:
OUTPUT_SIZE, 10, number of FC output scores per frame
DATA_WIDTH, 16, score width; signed two's complement Q8.8
ADDR_WIDTH, $clog2(OUTPUT_SIZE), score index width (minimum 1)

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  synchronous, active-low reset
in_data  in  DATA_WIDTH  FC output_data
in_valid  in  1  FC output_valid; qualifies in_data/in_addr
in_addr  in  ADDR_WIDTH  FC output_addr; score index
in_done  in  1  FC fc_done; level-sensitive, acted on only in COLLECT
rd_addr  in  ADDR_WIDTH  readback index
rd_data  out  DATA_WIDTH  buffer[rd_addr], registered
class_idx  out  ADDR_WIDTH  argmax index
class_score  out  DATA_WIDTH  score at class_idx
result_valid  out  1  class_idx/class_score are valid
busy  out  1  high in SCAN
missing_err  out  1  sticky per frame: at least one index not written before in_done
addr_err  out  1  sticky per frame: in_valid received with in_addr >= OUTPUT_SIZE

Behaviour:
- Reset (reset==0 at a clk edge): state=COLLECT. Buffer, write mask, rd_data, class_idx, class_score, result_valid, busy, missing_err and addr_err all go to 0.
- States:
  - COLLECT: accepts writes.
  - SCAN: runs the argmax.
  - DONE: holds the result.
- COLLECT:
  - in_valid with in_addr < OUTPUT_SIZE: writes buffer[in_addr] and sets mask[in_addr]. Rewriting an index overwrites it and is not an error.
  - in_valid with in_addr out of range: no write; addr_err set.
  - in_done high: go to SCAN the next cycle. A write in the same cycle is captured and is included in the scan.
  - On the COLLECT->SCAN edge: missing_err <= ~&mask.
- SCAN:
  - busy=1. Index counter runs 0..OUTPUT_SIZE-1, one element per cycle.
  - Running max is initialised from element 0. Later elements replace it only if strictly greater (signed compare), so ties resolve to the lowest index.
  - Unwritten entries take part with their current buffer value: 0 after reset, otherwise the stale previous-frame value.
  - SCAN lasts exactly OUTPUT_SIZE cycles. On the last element, state goes to DONE and result_valid=1 on the next edge.
  - Latency: result_valid rises OUTPUT_SIZE+1 cycles after the edge that samples in_done.
  - in_valid during SCAN is ignored with no error.
  - in_done during SCAN has no effect.
- DONE:
  - Holds result_valid, class_idx, class_score and the error flags.
  - in_done is ignored.
  - First in_valid starts a new frame: state=COLLECT. Mask, result_valid, missing_err and addr_err clear. That same beat is written normally (or flags addr_err if out of range).
- Readback:
  - rd_data <= buffer[rd_addr] every cycle in all states; 1-cycle latency.
  - Same-cycle write to the same address returns the old value.
  - rd_addr >= OUTPUT_SIZE returns 0.
- Reset mid-SCAN or mid-COLLECT: abandons the frame immediately; all state returns to the reset values above.
- No arithmetic beyond the signed compare; no saturation or scaling.

Decomposition:
- Shared package cnn_pkg: DATA_WIDTH, FRAC_BITS=8, FC_OUTPUT_SIZE=10, and the collector state enum (COLLECT, SCAN, DONE).
- No sub-module. Buffer, scan counter and comparator live in one module.

Test Plan:
- Write scores 0x0010,0x0200,0xFF00,0x0100,0x0000,0x0050,0x0020,0x0001,0x0180,0x0030 to addr 0..9, then pulse in_done -> busy for 10 cycles; result_valid 11 cycles after the in_done edge; class_idx=1, class_score=0x0200; missing_err=0, addr_err=0.
- Write all ten as 0xFF80 except addr 3 and addr 7 = 0x0040 -> class_idx=3 (tie goes to lowest index); all-negative variant with max 0xFFFE at addr 9 -> class_idx=9.
- Write only addr 0..8 with 0xF000 and skip addr 9 -> missing_err=1; class_idx=9, score=0x0000 after reset.
- in_valid with in_addr=12 (ADDR_WIDTH=4) -> no buffer change, addr_err=1. Then, after DONE, the first in_valid of a new frame -> addr_err, missing_err and result_valid clear the next cycle.
- Sweep rd_addr 0..9 after a frame -> rd_data matches the written values one cycle later; rd_addr=15 -> 0.
- Assert reset=0 in the 5th SCAN cycle -> next edge: busy=0, result_valid=0, rd_data=0; a subsequent full frame scans correctly.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the conv2d -> max_pool -> fully_connected chain.
package cnn_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int FRAC_BITS      = 8;
  localparam int FC_OUTPUT_SIZE = 10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } collector_state_t;

endpackage

// File: rtl/fc_result_collector.sv
// Captures the FC score stream into a local buffer, then runs a sequential
// signed argmax over it and holds the winning index and score.
//
// state   | meaning
// --------+----------------------------------------------------------
// COLLECT | accepting addressed score writes; in_done starts the scan
// SCAN    | one buffer element compared per cycle, busy high
// DONE    | result held; first in_valid opens the next frame
module fc_result_collector #(
  parameter int OUTPUT_SIZE = cnn_pkg::FC_OUTPUT_SIZE,
  parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] class_idx,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  missing_err,
  output logic                  addr_err
);
  import cnn_pkg::*;

  localparam logic [ADDR_WIDTH:0]   SIZE_EXT = (ADDR_WIDTH+1)'(OUTPUT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUTPUT_SIZE - 1);

  collector_state_t state, state_next;

  logic [DATA_WIDTH-1:0]  buffer [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0] mask;
  logic [OUTPUT_SIZE-1:0] wr_onehot;
  logic [ADDR_WIDTH-1:0]  scan_idx;
  logic [DATA_WIDTH-1:0]  scan_val;
  logic                   in_range;
  logic                   rd_in_range;
  logic                   accept;
  logic                   wr_en;

  assign in_range    = {1'b0, in_addr} < SIZE_EXT;
  assign rd_in_range = {1'b0, rd_addr} < SIZE_EXT;
  assign accept      = in_valid && (state == COLLECT || state == DONE);
  assign wr_en       = accept && in_range;
  assign scan_val    = buffer[scan_idx];

  always_comb begin
    wr_onehot = '0;
    if (wr_en) wr_onehot[in_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (in_done)               state_next = SCAN;
      SCAN:    if (scan_idx == LAST_IDX)  state_next = DONE;
      DONE:    if (in_valid)              state_next = COLLECT;
      default:                            state_next = COLLECT;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) buffer[i] <= '0;
      mask         <= '0;
      rd_data      <= '0;
      class_idx    <= '0;
      class_score  <= '0;
      result_valid <= 1'b0;
      missing_err  <= 1'b0;
      addr_err     <= 1'b0;
      scan_idx     <= '0;
    end else begin
      // Nonblocking read: a same-cycle write to rd_addr returns the old value.
      rd_data <= rd_in_range ? buffer[rd_addr] : '0;
      if (wr_en) buffer[in_addr] <= in_data;

      case (state)
        COLLECT: begin
          mask <= mask | wr_onehot;
          if (accept && !in_range) addr_err <= 1'b1;
          if (in_done) begin
            missing_err <= ~&(mask | wr_onehot);
            scan_idx    <= '0;
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          // Strict compare keeps the lowest index on ties.
          if (scan_idx == '0 || $signed(scan_val) > $signed(class_score)) begin
            class_idx   <= scan_idx;
            class_score <= scan_val;
          end
        end
        DONE: begin
          if (in_valid) begin
            mask         <= wr_onehot;
            result_valid <= 1'b0;
            missing_err  <= 1'b0;
            addr_err     <= !in_range;
          end else begin
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
